// File: rtl/cpu_agu.sv
`default_nettype none
// ============================================================================
// Module   : cpu_agu
// Desc     : 6502-style addressing-mode sequencer producing bus addresses and
//            the resolved effective address for IMM..IND modes.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_agu #(
    parameter  int DATA_W    = 8,
    parameter  int FORCE_FIX = 0,
    parameter  int PAGE_BUG  = 1,
    localparam int ADDR_W    = 2 * DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    input  logic              start,
    input  logic [3:0]        mode,
    input  logic [DATA_W-1:0] X,
    input  logic [DATA_W-1:0] Y,
    input  logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] d_in,
    output logic [ADDR_W-1:0] addr,
    output logic              pc_inc,
    output logic              busy,
    output logic              ea_valid,
    output logic [ADDR_W-1:0] ea,
    output logic              page_cross
);

    localparam logic [3:0] c_IMM  = 4'd0;
    localparam logic [3:0] c_ZP   = 4'd1;
    localparam logic [3:0] c_ZPX  = 4'd2;
    localparam logic [3:0] c_ZPY  = 4'd3;
    localparam logic [3:0] c_ABS  = 4'd4;
    localparam logic [3:0] c_ABSX = 4'd5;
    localparam logic [3:0] c_ABSY = 4'd6;
    localparam logic [3:0] c_INDX = 4'd7;
    localparam logic [3:0] c_INDY = 4'd8;
    localparam logic [3:0] c_IND  = 4'd9;

    localparam logic [DATA_W-1:0] c_ZERO_D = '0;
    localparam logic [DATA_W-1:0] c_ONE_D  = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_ONE_A  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_OP1    = 3'd1,
        S_OP2    = 3'd2,
        S_ZIDX   = 3'd3,
        S_PTR_LO = 3'd4,
        S_PTR_HI = 3'd5,
        S_FIX    = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t              r_state, w_state;
    logic [3:0]          r_mode, w_mode;
    logic [DATA_W-1:0]   r_x, w_x, r_y, w_y;
    logic [DATA_W-1:0]   r_adl, w_adl, r_adh, w_adh, r_bal, w_bal, r_tlo, w_tlo;
    logic                r_c, w_c;
    logic [ADDR_W-1:0]   r_ea, w_ea;
    logic                r_pcross, w_pcross;

    logic [DATA_W-1:0]   w_idx;
    logic [DATA_W:0]     w_sum;
    logic                w_need_fix;
    logic                w_indexed;

    always_comb begin
        w_state  = r_state;
        w_mode   = r_mode;
        w_x      = r_x;
        w_y      = r_y;
        w_adl    = r_adl;
        w_adh    = r_adh;
        w_bal    = r_bal;
        w_tlo    = r_tlo;
        w_c      = r_c;
        w_ea     = r_ea;
        w_pcross = r_pcross;
        addr     = pc;
        pc_inc   = 1'b0;
        ea_valid = 1'b0;

        w_idx      = (r_mode == c_ZPY || r_mode == c_ABSY || r_mode == c_INDY) ? r_y : r_x;
        w_sum      = {1'b0, d_in} + {1'b0, w_idx};
        w_need_fix = r_c || (FORCE_FIX != 0);
        w_indexed  = (r_mode == c_ABSX || r_mode == c_ABSY || r_mode == c_INDY);

        case (r_state)
            S_IDLE: begin
                if (start && ready) begin
                    w_mode = mode;
                    w_x    = X;
                    w_y    = Y;
                    w_c    = 1'b0;
                    if (mode > c_IND) begin
                        w_ea     = pc;
                        w_pcross = 1'b0;
                        w_state  = S_DONE;
                    end else begin
                        w_state = S_OP1;
                    end
                end
            end
            S_OP1: begin
                pc_inc = ready;
                if (ready) begin
                    case (r_mode)
                        c_IMM: begin
                            w_ea     = pc;
                            w_pcross = 1'b0;
                            w_state  = S_DONE;
                        end
                        c_ZP: begin
                            w_adl    = d_in;
                            w_ea     = {c_ZERO_D, d_in};
                            w_pcross = 1'b0;
                            w_state  = S_DONE;
                        end
                        c_ZPX, c_ZPY: begin
                            w_adl   = d_in;
                            w_state = S_ZIDX;
                        end
                        c_ABSX, c_ABSY: begin
                            {w_c, w_adl} = w_sum;
                            w_state      = S_OP2;
                        end
                        c_ABS, c_IND: begin
                            w_adl   = d_in;
                            w_state = S_OP2;
                        end
                        c_INDX: begin
                            w_bal   = d_in;
                            w_state = S_ZIDX;
                        end
                        c_INDY: begin
                            w_bal   = d_in;
                            w_state = S_PTR_LO;
                        end
                        default: w_state = S_DONE;
                    endcase
                end
            end
            S_OP2: begin
                pc_inc = ready;
                if (ready) begin
                    w_adh = d_in;
                    if (r_mode == c_IND) begin
                        w_state = S_PTR_LO;
                    end else if (w_indexed && w_need_fix) begin
                        w_state = S_FIX;
                    end else begin
                        w_ea     = {d_in, r_adl};
                        w_pcross = w_indexed && r_c;
                        w_state  = S_DONE;
                    end
                end
            end
            S_ZIDX: begin
                // Dummy read of the unindexed zero-page location
                if (r_mode == c_INDX) begin
                    addr = {c_ZERO_D, r_bal};
                    if (ready) begin
                        w_bal   = r_bal + r_x;
                        w_state = S_PTR_LO;
                    end
                end else begin
                    addr = {c_ZERO_D, r_adl};
                    if (ready) begin
                        w_adl    = r_adl + w_idx;
                        w_ea     = {c_ZERO_D, r_adl + w_idx};
                        w_pcross = 1'b0;
                        w_state  = S_DONE;
                    end
                end
            end
            S_PTR_LO: begin
                if (r_mode == c_IND) begin
                    addr = {r_adh, r_adl};
                    if (ready) w_tlo = d_in;
                end else begin
                    addr = {c_ZERO_D, r_bal};
                    if (ready) begin
                        if (r_mode == c_INDY) {w_c, w_adl} = w_sum;
                        else                  w_adl = d_in;
                    end
                end
                if (ready) w_state = S_PTR_HI;
            end
            S_PTR_HI: begin
                if (r_mode == c_IND) begin
                    // NMOS quirk: pointer high byte never leaves the pointer's page
                    addr = (PAGE_BUG != 0) ? {r_adh, r_adl + c_ONE_D} : ({r_adh, r_adl} + c_ONE_A);
                    if (ready) begin
                        w_ea     = {d_in, r_tlo};
                        w_pcross = 1'b0;
                        w_state  = S_DONE;
                    end
                end else begin
                    addr = {c_ZERO_D, r_bal + c_ONE_D};
                    if (ready) begin
                        w_adh = d_in;
                        if (r_mode == c_INDY && w_need_fix) begin
                            w_state = S_FIX;
                        end else begin
                            w_ea     = {d_in, r_adl};
                            w_pcross = (r_mode == c_INDY) && r_c;
                            w_state  = S_DONE;
                        end
                    end
                end
            end
            S_FIX: begin
                addr = {r_adh, r_adl};
                if (ready) begin
                    w_adh    = r_adh + {{(DATA_W-1){1'b0}}, r_c};
                    w_ea     = {r_adh + {{(DATA_W-1){1'b0}}, r_c}, r_adl};
                    w_pcross = r_c;
                    w_state  = S_DONE;
                end
            end
            S_DONE: begin
                ea_valid = 1'b1;
                w_state  = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_mode   <= 4'd0;
            r_x      <= '0;
            r_y      <= '0;
            r_adl    <= '0;
            r_adh    <= '0;
            r_bal    <= '0;
            r_tlo    <= '0;
            r_c      <= 1'b0;
            r_ea     <= '0;
            r_pcross <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_mode   <= w_mode;
            r_x      <= w_x;
            r_y      <= w_y;
            r_adl    <= w_adl;
            r_adh    <= w_adh;
            r_bal    <= w_bal;
            r_tlo    <= w_tlo;
            r_c      <= w_c;
            r_ea     <= w_ea;
            r_pcross <= w_pcross;
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign ea         = r_ea;
    assign page_cross = r_pcross;

endmodule
`default_nettype wire

// File: tb/tb_cpu_agu.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_agu
// Desc     : Directed self-checking bench for cpu_agu (two parameter variants).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_agu;

    logic        clk = 1'b0;
    logic        reset, ready, start;
    logic [3:0]  mode;
    logic [7:0]  X, Y;
    logic [15:0] pc0, pc1, addr0, addr1, ea0, ea1;
    logic [7:0]  d0, d1;
    logic        inc0, inc1, busy0, busy1, ev0, ev1, pcr0, pcr1;
    logic        pc_set;
    logic [15:0] pc_val;
    logic [7:0]  mem [0:65535];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          nb, lat;
    logic [15:0] tr_addr [0:63];
    logic        tr_inc  [0:63];
    logic [15:0] obs_ea, obs_pc;
    logic        obs_pcr, obs_ev;

    always #5 clk = ~clk;

    assign d0 = mem[addr0];
    assign d1 = mem[addr1];

    // Program counter model: each DUT variant advances its own PC
    always @(posedge clk) begin
        if (pc_set) begin
            pc0 <= pc_val;
            pc1 <= pc_val;
        end else begin
            if (inc0) pc0 <= pc0 + 16'd1;
            if (inc1) pc1 <= pc1 + 16'd1;
        end
    end

    cpu_agu #(.DATA_W(8), .FORCE_FIX(0), .PAGE_BUG(1)) u_dut0 (
        .clk(clk), .reset(reset), .ready(ready), .start(start), .mode(mode),
        .X(X), .Y(Y), .pc(pc0), .d_in(d0), .addr(addr0), .pc_inc(inc0),
        .busy(busy0), .ea_valid(ev0), .ea(ea0), .page_cross(pcr0)
    );

    cpu_agu #(.DATA_W(8), .FORCE_FIX(1), .PAGE_BUG(0)) u_dut1 (
        .clk(clk), .reset(reset), .ready(ready), .start(start), .mode(mode),
        .X(X), .Y(Y), .pc(pc1), .d_in(d1), .addr(addr1), .pc_inc(inc1),
        .busy(busy1), .ea_valid(ev1), .ea(ea1), .page_cross(pcr1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_pc(input logic [15:0] v);
        pc_val = v;
        pc_set = 1'b1;
        @(posedge clk);
        #1;
        pc_set = 1'b0;
    endtask

    // Issue one request and trace the watched variant until its ea_valid
    task automatic run_op(input int sel, input logic [3:0] m, input logic [7:0] xv,
                          input logic [7:0] yv, input int st_at, input int st_len);
        mode  = m;
        X     = xv;
        Y     = yv;
        start = 1'b1;
        ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = 4'hF;
        X     = 8'h00;
        Y     = 8'h00;
        nb    = 0;
        while (((sel == 0) ? ev0 : ev1) !== 1'b1 && nb < 40) begin
            ready = (nb >= st_at && nb < st_at + st_len) ? 1'b0 : 1'b1;
            #1;
            tr_addr[nb] = (sel == 0) ? addr0 : addr1;
            tr_inc[nb]  = (sel == 0) ? inc0 : inc1;
            @(posedge clk);
            #1;
            nb++;
        end
        ready   = 1'b1;
        obs_ev  = (sel == 0) ? ev0 : ev1;
        obs_ea  = (sel == 0) ? ea0 : ea1;
        obs_pcr = (sel == 0) ? pcr0 : pcr1;
        obs_pc  = (sel == 0) ? pc0 : pc1;
        lat     = nb + 1;
        check("ea_valid_seen", obs_ev, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0200] = 8'hF0;
        mem[16'h0300] = 8'hFF; mem[16'h0301] = 8'h12;
        mem[16'h0400] = 8'hFF; mem[16'h00FF] = 8'h80; mem[16'h0000] = 8'h40;
        mem[16'h0500] = 8'hFF; mem[16'h0501] = 8'h30;
        mem[16'h30FF] = 8'h34; mem[16'h3000] = 8'h12; mem[16'h3100] = 8'h56;
        mem[16'h0600] = 8'h34; mem[16'h0601] = 8'h12;
        mem[16'h0700] = 8'h10; mem[16'h0015] = 8'h78; mem[16'h0016] = 8'h56;
        mem[16'h0A00] = 8'h44;

        reset = 1'b1; ready = 1'b1; start = 1'b0; mode = 4'd0; X = 8'h00; Y = 8'h00;
        pc_set = 1'b1; pc_val = 16'h0100;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy0, 1'b0);
        check("rst_ea", ea0, 16'h0000);
        check("rst_pcross", pcr0, 1'b0);
        check("rst_ea_valid", ev0, 1'b0);
        check("rst_pc_inc", inc0, 1'b0);
        check("rst_addr", addr0, 16'h0100);
        reset = 1'b0;
        pc_set = 1'b0;
        idle(2);

        // ZPX with zero-page wrap
        load_pc(16'h0200);
        run_op(0, 4'd2, 8'h20, 8'h00, 99, 0);
        check("zpx_op1_addr", tr_addr[0], 16'h0200);
        check("zpx_op1_inc", tr_inc[0], 1'b1);
        check("zpx_dummy_addr", tr_addr[1], 16'h00F0);
        check("zpx_dummy_inc", tr_inc[1], 1'b0);
        check("zpx_ea", obs_ea, 16'h0010);
        check("zpx_pcross", obs_pcr, 1'b0);
        check("zpx_latency", lat, 3);
        idle(4);

        // ABSX with carry takes FIX
        load_pc(16'h0300);
        run_op(0, 4'd5, 8'h01, 8'h00, 99, 0);
        check("absx1_fix_addr", tr_addr[2], 16'h1200);
        check("absx1_ea", obs_ea, 16'h1300);
        check("absx1_pcross", obs_pcr, 1'b1);
        check("absx1_latency", lat, 4);
        check("absx1_pc", obs_pc, 16'h0302);
        idle(4);

        // ABSX without carry skips FIX
        load_pc(16'h0300);
        run_op(0, 4'd5, 8'h00, 8'h00, 99, 0);
        check("absx0_ea", obs_ea, 16'h12FF);
        check("absx0_pcross", obs_pcr, 1'b0);
        check("absx0_latency", lat, 3);
        idle(4);

        // FORCE_FIX variant always takes FIX but reports no crossing
        load_pc(16'h0300);
        run_op(1, 4'd5, 8'h00, 8'h00, 99, 0);
        check("ffix_fix_addr", tr_addr[2], 16'h12FF);
        check("ffix_ea", obs_ea, 16'h12FF);
        check("ffix_pcross", obs_pcr, 1'b0);
        check("ffix_latency", lat, 4);
        idle(4);

        // INDY with pointer at zero-page wrap
        load_pc(16'h0400);
        run_op(0, 4'd8, 8'h00, 8'h90, 99, 0);
        check("indy_ptrlo_addr", tr_addr[1], 16'h00FF);
        check("indy_ptrhi_addr", tr_addr[2], 16'h0000);
        check("indy_fix_addr", tr_addr[3], 16'h4010);
        check("indy_ea", obs_ea, 16'h4110);
        check("indy_pcross", obs_pcr, 1'b1);
        idle(4);

        // IND page-wrap quirk on, then off
        load_pc(16'h0500);
        run_op(0, 4'd9, 8'h00, 8'h00, 99, 0);
        check("ind_bug_ptrlo", tr_addr[2], 16'h30FF);
        check("ind_bug_ptrhi", tr_addr[3], 16'h3000);
        check("ind_bug_ea", obs_ea, 16'h1234);
        idle(4);
        load_pc(16'h0500);
        run_op(1, 4'd9, 8'h00, 8'h00, 99, 0);
        check("ind_nobug_ptrhi", tr_addr[3], 16'h3100);
        check("ind_nobug_ea", obs_ea, 16'h5634);
        idle(4);

        // ABS with three stall cycles in OP2
        load_pc(16'h0600);
        run_op(0, 4'd4, 8'h00, 8'h00, 1, 3);
        check("stall_addr", tr_addr[3], 16'h0601);
        check("stall_inc", tr_inc[2], 1'b0);
        check("stall_resume_inc", tr_inc[4], 1'b1);
        check("stall_ea", obs_ea, 16'h1234);
        check("stall_latency", lat, 6);
        check("stall_pc", obs_pc, 16'h0602);
        @(posedge clk);
        #1;
        check("stall_single_pulse", ev0, 1'b0);
        check("stall_idle_busy", busy0, 1'b0);
        idle(3);

        // IMM, ZP, reserved
        load_pc(16'h0800);
        run_op(0, 4'd0, 8'h00, 8'h00, 99, 0);
        check("imm_ea", obs_ea, 16'h0800);
        check("imm_latency", lat, 2);
        check("imm_pc", obs_pc, 16'h0801);
        idle(3);
        load_pc(16'h0A00);
        run_op(0, 4'd1, 8'h00, 8'h00, 99, 0);
        check("zp_ea", obs_ea, 16'h0044);
        idle(3);
        load_pc(16'h0900);
        run_op(0, 4'd12, 8'h00, 8'h00, 99, 0);
        check("rsvd_ea", obs_ea, 16'h0900);
        check("rsvd_latency", lat, 1);
        check("rsvd_pc", obs_pc, 16'h0900);
        idle(3);

        // INDX full run
        load_pc(16'h0700);
        run_op(0, 4'd7, 8'h05, 8'h00, 99, 0);
        check("indx_dummy_addr", tr_addr[1], 16'h0010);
        check("indx_ptrlo_addr", tr_addr[2], 16'h0015);
        check("indx_ptrhi_addr", tr_addr[3], 16'h0016);
        check("indx_ea", obs_ea, 16'h5678);
        check("indx_latency", lat, 5);
        idle(3);

        // Reset in PTR_LO of INDX
        load_pc(16'h0700);
        mode = 4'd7; X = 8'h05; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midrst_ptrlo_addr", addr0, 16'h0015);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_busy", busy0, 1'b0);
        check("midrst_ea", ea0, 16'h0000);
        check("midrst_addr", addr0, 16'h0701);
        check("midrst_pc_inc", inc0, 1'b0);
        idle(2);
        load_pc(16'h0700);
        run_op(0, 4'd7, 8'h05, 8'h00, 99, 0);
        check("postrst_ea", obs_ea, 16'h5678);
        check("postrst_latency", lat, 5);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_agu.md
CPU_AGU -- requirements
Module: cpu_agu

Interface
REQ-001 Parameter DATA_W, default 8, data/index width; ADDR_W = 2*DATA_W (derived, not overridable).
REQ-002 Parameter FORCE_FIX, default 0; 1 = indexed absolute/(ind),Y always take FIX cycle (store timing).
REQ-003 Parameter PAGE_BUG, default 1; 1 = IND pointer high-byte fetch wraps within page (NMOS behaviour).
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 ready  in  1  bus ready; 0 stalls current bus cycle.
REQ-007 start  in  1  request address resolution; sampled in IDLE only.
REQ-008 mode  in  4  0 IMM,1 ZP,2 ZPX,3 ZPY,4 ABS,5 ABSX,6 ABSY,7 INDX,8 INDY,9 IND; 10-15 reserved.
REQ-009 X, Y  in  DATA_W each  index registers, latched at start.
REQ-010 pc  in  ADDR_W  current program counter.
REQ-011 d_in  in  DATA_W  read data, valid same cycle as addr.
REQ-012 addr  out  ADDR_W  bus address (combinational from state/registers).
REQ-013 pc_inc  out  1  advance PC this cycle.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 ea_valid  out  1  one-cycle pulse, ea/page_cross valid.
REQ-016 ea  out  ADDR_W  resolved effective address, held until next ea_valid.
REQ-017 page_cross  out  1  index addition carried out of low byte.

Function
REQ-018 States SHALL be IDLE, OP1, OP2, ZIDX, PTR_LO, PTR_HI, FIX, DONE.
REQ-019 IDLE: start=1 and ready=1 latches mode/X/Y, goes OP1 (reserved modes go DONE, ea=pc, no pc_inc).
REQ-020 Bus states (OP1..FIX): ready=0 holds state, all internal registers, addr, and forces pc_inc=0.
REQ-021 OP1/OP2: addr=pc, pc_inc=1; IMM in OP1 captures ea=pc and goes DONE.
REQ-022 ZP: OP1 ADL<=d_in -> DONE, ea={0,ADL}.
REQ-023 ZPX/ZPY: OP1 ADL<=d_in; ZIDX addr={0,ADL} dummy read, ADL<=(ADL+idx) mod 2^DATA_W -> DONE; never page_cross.
REQ-024 ABS: OP1 ADL<=d_in; OP2 ADH<=d_in -> DONE.
REQ-025 ABSX/ABSY: OP1 {c,ADL}<=d_in+idx; OP2 ADH<=d_in; c=1 or FORCE_FIX -> FIX, else DONE.
REQ-026 FIX: addr={ADH,ADL} dummy read; ADH<=ADH+c (mod 2^DATA_W) -> DONE.
REQ-027 INDX: OP1 BAL<=d_in; ZIDX addr={0,BAL}, BAL<=BAL+X mod; PTR_LO addr={0,BAL}, ADL<=d_in; PTR_HI addr={0,BAL+1 mod}, ADH<=d_in -> DONE.
REQ-028 INDY: OP1 BAL<=d_in; PTR_LO addr={0,BAL}, {c,ADL}<=d_in+Y; PTR_HI addr={0,BAL+1 mod}, ADH<=d_in; then as REQ-025 FIX rule.
REQ-029 IND: OP1 ADL, OP2 ADH (pointer); PTR_LO addr={ADH,ADL}, TLO<=d_in; PTR_HI addr={ADH,ADL+1 mod} if PAGE_BUG else {ADH,ADL}+1 mod 2^ADDR_W; ea={d_in,TLO} -> DONE.
REQ-030 DONE: ea_valid=1, addr=pc, pc_inc=0, independent of ready; next state IDLE; start ignored.
REQ-031 page_cross = c for ABSX/ABSY/INDY, else 0; FORCE_FIX does not set it.
REQ-032 pc_inc=0 in ZIDX, PTR_LO, PTR_HI, FIX, DONE, IDLE.

Reset
REQ-033 reset=1 SHALL force IDLE, addr=pc, pc_inc=0, busy=0, ea_valid=0, ea=0, page_cross=0, internal registers 0, overriding any state incl. mid-sequence and stall.

Verification
REQ-034 ZPX, pc=0x0200, d_in=0xF0, X=0x20 -> ZIDX dummy at 0x00F0, ea=0x0010, page_cross=0, 3 cycles to ea_valid.
REQ-035 ABSX, operands 0xFF,0x12, X=0x01 -> FIX addr 0x1200, ea=0x1300, page_cross=1; X=0x00 -> no FIX, ea=0x12FF.
REQ-036 INDY, zp=0xFF, mem[0xFF]=0x80, mem[0x00]=0x40, Y=0x90 -> PTR_HI addr 0x0000, ea=0x4110, page_cross=1.
REQ-037 IND, pointer 0x30FF, PAGE_BUG=1 -> high fetch at 0x3000; PAGE_BUG=0 -> 0x3100.
REQ-038 ABS with ready=0 for 3 cycles in OP2 -> addr, state held, pc_inc=0 during stall; ea_valid exactly once.
REQ-039 reset asserted in PTR_LO of INDX -> next cycle IDLE, busy=0, ea=0; new start proceeds normally.
